reg_file_sb: RTL

//  Unified general/float register file with a scoreboard for multi-cycle results.

---
 rtl/reg_pkg.sv | 13 +
 rtl/reg_file_sb_if.sv | 33 +++
 rtl/reg_bank.sv | 57 +++++
 rtl/reg_file_sb.sv | 83 ++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared defaults and address/data types for the unified general/float register file.
package reg_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 16;
  localparam int AW   = $clog2(NREG);

  typedef struct packed {
    logic          fflag;
    logic [AW-1:0] num;
  } reg_addr_t;

  typedef logic [XLEN-1:0] reg_data_t;
endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/issue + writeback bus of the register file; master = pipeline, slave = reg_file_sb.
interface reg_file_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 16,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic                 wr_en;
  logic                 wr_fflag;
  logic [AW-1:0]        wr_num;
  logic [XLEN-1:0]      wr_data;
  logic [NRD-1:0]       rd_fflag;
  logic [NRD*AW-1:0]    rd_num;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 iss_valid;
  logic                 iss_fflag;
  logic [AW-1:0]        iss_num;
  logic                 iss_ready;

  modport master (
    output wr_en, wr_fflag, wr_num, wr_data, rd_fflag, rd_num,
    output iss_valid, iss_fflag, iss_num,
    input  rd_data, rd_busy, iss_ready
  );

  modport slave (
    input  wr_en, wr_fflag, wr_num, wr_data, rd_fflag, rd_num,
    input  iss_valid, iss_fflag, iss_num,
    output rd_data, rd_busy, iss_ready
  );
endinterface

// File: rtl/reg_bank.sv
// One register bank: NREG x XLEN storage, busy scoreboard, one write port, NRD read ports.
// ZERO_EN makes entry 0 a hardwired zero that can never be written or reserved.
module reg_bank #(
  parameter int XLEN    = 32,
  parameter int NREG    = 16,
  parameter int NRD     = 2,
  parameter bit ZERO_EN = 1'b0,
  parameter int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_en,
  input  logic [AW-1:0]       i_wr_num,
  input  logic [XLEN-1:0]     i_wr_data,
  input  logic                i_set_en,
  input  logic [AW-1:0]       i_set_num,
  input  logic [NRD*AW-1:0]   i_rd_num,
  output logic [NRD*XLEN-1:0] o_rd_data,
  output logic [NRD-1:0]      o_rd_busy,
  output logic [NREG-1:0]     o_busy_vec
);
  logic [XLEN-1:0] r_mem [NREG];
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_wr_ok;

  assign w_wr_ok = i_wr_en && !(ZERO_EN && (i_wr_num == '0));

  // A reservation in the same cycle as the writeback overrides the clear.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_wr_en)  w_busy_nxt[i_wr_num]  = 1'b0;
    if (i_set_en) w_busy_nxt[i_set_num] = 1'b1;
    if (ZERO_EN)  w_busy_nxt[0]         = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr_ok) r_mem[i_wr_num] <= i_wr_data;
      r_busy <= w_busy_nxt;
    end
  end

  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      o_rd_data[p*XLEN +: XLEN] = r_mem[i_rd_num[p*AW +: AW]];
      o_rd_busy[p]              = r_busy[i_rd_num[p*AW +: AW]];
    end
  end

  assign o_busy_vec = r_busy;
endmodule

// File: rtl/reg_file_sb.sv
// Unified general/float register file with result scoreboard; general r0 reads as zero.
// Define REGFILE_BYPASS_EN for write-to-read forwarding (0-cycle latency, busy drops same cycle).
module reg_file_sb #(
  parameter int XLEN = reg_pkg::XLEN,
  parameter int NREG = reg_pkg::NREG,
  parameter int NRD  = 2
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  logic [NRD*XLEN-1:0] w_g_rd_data, w_f_rd_data, w_rd_data;
  logic [NRD-1:0]      w_g_rd_busy, w_f_rd_busy, w_rd_busy;
  logic [NREG-1:0]     w_g_busy, w_f_busy;
  logic                w_tgt_busy, w_wr_hit, w_iss_ready, w_set_en;

  // A writeback to the target frees it in time for a reservation on the same edge.
  assign w_tgt_busy  = bus.iss_fflag ? w_f_busy[bus.iss_num] : w_g_busy[bus.iss_num];
  assign w_wr_hit    = bus.wr_en && (bus.wr_fflag == bus.iss_fflag) && (bus.wr_num == bus.iss_num);
  assign w_iss_ready = !w_tgt_busy || w_wr_hit;
  assign w_set_en    = bus.iss_valid && w_iss_ready;

  reg_bank #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_EN(1'b1)) u_gen (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (bus.wr_en && !bus.wr_fflag),
    .i_wr_num   (bus.wr_num),
    .i_wr_data  (bus.wr_data),
    .i_set_en   (w_set_en && !bus.iss_fflag),
    .i_set_num  (bus.iss_num),
    .i_rd_num   (bus.rd_num),
    .o_rd_data  (w_g_rd_data),
    .o_rd_busy  (w_g_rd_busy),
    .o_busy_vec (w_g_busy)
  );

  reg_bank #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_EN(1'b0)) u_flt (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (bus.wr_en && bus.wr_fflag),
    .i_wr_num   (bus.wr_num),
    .i_wr_data  (bus.wr_data),
    .i_set_en   (w_set_en && bus.iss_fflag),
    .i_set_num  (bus.iss_num),
    .i_rd_num   (bus.rd_num),
    .o_rd_data  (w_f_rd_data),
    .o_rd_busy  (w_f_rd_busy),
    .o_busy_vec (w_f_busy)
  );

`ifdef REGFILE_BYPASS_EN
  logic w_wr_live;
  // Writes to general r0 are dropped, so they must not be forwarded either.
  assign w_wr_live = bus.wr_en && !(!bus.wr_fflag && (bus.wr_num == '0));
`endif

  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      if (bus.rd_fflag[p]) begin
        w_rd_data[p*XLEN +: XLEN] = w_f_rd_data[p*XLEN +: XLEN];
        w_rd_busy[p]              = w_f_rd_busy[p];
      end else begin
        w_rd_data[p*XLEN +: XLEN] = w_g_rd_data[p*XLEN +: XLEN];
        w_rd_busy[p]              = w_g_rd_busy[p];
      end
`ifdef REGFILE_BYPASS_EN
      if (w_wr_live && (bus.wr_fflag == bus.rd_fflag[p]) &&
          (bus.wr_num == bus.rd_num[p*AW +: AW])) begin
        w_rd_data[p*XLEN +: XLEN] = bus.wr_data;
        w_rd_busy[p]              = 1'b0;
      end
`endif
    end
  end

  assign bus.rd_data   = w_rd_data;
  assign bus.rd_busy   = w_rd_busy;
  assign bus.iss_ready = w_iss_ready;
endmodule
